// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//
// Round-robin arbiter that shares one 4:1 select-driven mux between four
// requesters (switch banks A..D = req[0]..req[3]). One requester at a time
// owns the mux. Ownership ends in one of three ways:
//   - the owner drops its request line,
//   - the owner reaches MAX_HOLD consecutive grant cycles (it is preempted),
//   - a reset.
// Every tenure is followed by one break-before-make GAP cycle and one IDLE
// arbitration cycle. The winner search starts one past the last-granted
// index, so a preempted requester that keeps asserting req drops to the
// lowest priority.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high, overrides everything
//   en         arbitration enable; gates new grants, never preempts
//   req[3:0]   request per requester
//   gnt[3:0]   one-hot grant, registered
//   sel        mux select = index of the granted requester, registered;
//              holds the last granted index between tenures
//   sel_valid  high while a grant is active; qualifies sel
//   timeout    one-cycle pulse in the GAP that follows a MAX_HOLD preemption
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; arbitrate among req when en=1
// BUSY  | grant active for requester 'last'; hold counter running
// GAP   | one dead cycle after a tenure (break-before-make)

module mux_rr_arbiter #(
  parameter int SEL_WIDTH = 2,
  parameter int MAX_HOLD  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [3:0]           req,
  output logic [3:0]           gnt,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 sel_valid,
  output logic                 timeout
);

  localparam int NUM_REQ = 4;

  // The counter only has to reach MAX_HOLD-1: the compare ends the tenure
  // before it could ever wrap.
  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [SEL_WIDTH-1:0] last;

  logic                 win_found;
  logic [SEL_WIDTH-1:0] win_idx;

  // Circular search starting at last+1. The index sum is SEL_WIDTH bits
  // wide, so it wraps modulo 4 on its own. Offset 4 lands back on 'last',
  // which is how a lone requester can win twice in a row.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && req[last + SEL_WIDTH'(k)]) begin
        win_found = 1'b1;
        win_idx   = last + SEL_WIDTH'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      timeout   <= 1'b0;
      cnt       <= '0;
      last      <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (en && win_found) begin
            gnt       <= 4'b0001 << win_idx;
            sel       <= win_idx;
            sel_valid <= 1'b1;
            cnt       <= '0;
            last      <= win_idx;
            state     <= BUSY;
          end
        end

        BUSY: begin
          // A release in the final cycle counts as a normal release, so no
          // timeout pulse is raised for it.
          if (!req[last]) begin
            gnt       <= '0;
            sel_valid <= 1'b0;
            state     <= GAP;
          end else if (cnt == CNT_LAST) begin
            gnt       <= '0;
            sel_valid <= 1'b0;
            timeout   <= 1'b1;
            state     <= GAP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        GAP: begin
          timeout <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          gnt       <= '0;
          sel_valid <= 1'b0;
          timeout   <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares the team's 4:1 select-driven multiplexer between four requesters (switch banks A-D).
- Each requester raises a request line and holds it while it owns the mux.
- The block grants one requester at a time and drives the mux select with the winner's index.
- A hold-time limit and a one-cycle break-before-make gap keep any single source from starving the others.
- Sits between the requester logic and the mux select input.

Parameters:
SEL_WIDTH, 2, width of sel output; fixed at 2 for 4 requesters.
MAX_HOLD, 8, maximum consecutive grant cycles per tenure; legal range 2..255.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  arbitration enable; gates new grants only
req  input  4  request per requester, bit i = source i (0=A..3=D)
gnt  output  4  one-hot grant, registered
sel  output  SEL_WIDTH  mux select = index of granted requester, registered
sel_valid  output  1  high while a grant is active (sel is meaningful)
timeout  output  1  one-cycle pulse when a tenure is cut at MAX_HOLD

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. Reset takes priority over all other inputs in the same cycle.
- Reset values:
  - gnt=0, sel=0, sel_valid=0, timeout=0
  - state=IDLE, hold counter=0
  - last-granted pointer=3, so requester 0 has highest priority after reset
- State machine:
  - IDLE:
    - If en=1 and req!=0, choose the first set req bit searching circularly from (last+1) mod 4.
    - Next edge: gnt=onehot(winner), sel=winner, sel_valid=1, counter=0, last=winner, state BUSY.
    - Grant latency: 1 cycle from req sampled in IDLE.
    - If en=0 or req=0, stay in IDLE with outputs unchanged.
  - BUSY:
    - Counter increments each cycle the grant is held.
    - If req[last]=0: next edge gnt=0, sel_valid=0, state GAP (normal release).
    - Else if counter==MAX_HOLD-1: next edge gnt=0, sel_valid=0, timeout=1 for exactly that cycle, state GAP (preemption).
    - Otherwise hold. Total asserted-grant cycles per tenure ≤ MAX_HOLD.
    - en=0 does not preempt an active grant.
    - Changes on req bits other than last are ignored in BUSY.
  - GAP:
    - Exactly one cycle with gnt=0 and sel_valid=0. Unconditional transition to IDLE.
    - timeout clears to 0 on leaving GAP.
- Minimum spacing between grant tenures: 2 dead cycles (GAP + IDLE arbitration).
- sel is updated only when a grant is issued. In GAP/IDLE it holds the last granted index. Consumers must qualify sel with sel_valid.
- Fairness:
  - A preempted requester still asserting req becomes lowest priority, because last points to it.
  - With all four requesting continuously, grant order is 0,1,2,3,0,...
- Counter width: ceil(log2(MAX_HOLD)) bits. It never wraps, because the compare terminates the tenure first.
- gnt is never multi-hot. gnt!=0 if and only if sel_valid=1, and then sel equals the index of the gnt bit.
- rst asserted mid-tenure: next edge forces the reset values regardless of req; no timeout pulse.

Test Plan:
- Reset/idle: hold rst 2 cycles with req=4'b1111, then release with en=1 -> gnt=0, sel_valid=0, timeout=0 during reset; first grant is gnt=4'b0001, sel=0, 1 cycle after release.
- Normal release: req=4'b0100 held 3 cycles then dropped -> gnt=4'b0100, sel=2 for 3 cycles. Expected: gnt=0 one cycle after req falls, one GAP cycle, no timeout.
- Round-robin: req=4'b1111 held, MAX_HOLD=8 -> grants 0,1,2,3,0 in order. Expected: each tenure exactly 8 cycles with a timeout pulse, 2 dead cycles between tenures, never multi-hot.
- Priority skip: after grant to 1 completes, req=4'b0011 -> next grant to 0 (search 2,3,0). Then with req still 4'b0011 -> grant to 1.
- Enable gating: en=0 with req=4'b1000 -> no grant. Set en=1 -> gnt=4'b1000, sel=3 next cycle. Drop en mid-tenure -> grant continues until req[3] falls.
- Reset mid-operation: assert rst on cycle 4 of a tenure for source 2 -> next edge gnt=0, sel=0, sel_valid=0. After release with req=4'b0100 -> source 2 granted again, since pointer was reset to 3.
